// File: rtl/vga_sync_decoder.sv
// Recovers raster position, line/frame lengths and lock status from active-low hsync/vsync.
// Define VGA_DEC_SYNC_EN to insert a 2-flop synchronizer on hsync/vsync for asynchronous sources.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 521,
  parameter int unsigned HBP         = 144,
  parameter int unsigned HFP         = 784,
  parameter int unsigned VBP         = 31,
  parameter int unsigned VFP         = 511,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       valid,
  output logic       locked,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       line_err,
  output logic       frame_err
);

  // state    | meaning
  // SEARCH   | no frame boundary seen yet, no length checks
  // TRACK    | checking line/frame lengths, counting clean frames
  // LOCKED   | LOCK_FRAMES clean frames seen, valid enabled
  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [10:0] H_TOTAL_L = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_L = 11'(V_TOTAL);
  localparam logic [9:0]  HBP_L     = 10'(HBP);
  localparam logic [9:0]  HFP_L     = 10'(HFP);
  localparam logic [9:0]  VBP_L     = 10'(VBP);
  localparam logic [9:0]  VFP_L     = 10'(VFP);
  localparam logic [3:0]  LOCK_L    = 4'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX   = 10'h3FF;

  logic hs_in, vs_in;

`ifdef VGA_DEC_SYNC_EN
  logic [1:0] hs_sync_q, vs_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_sync_q <= 2'b11;
      vs_sync_q <= 2'b11;
    end else begin
      hs_sync_q <= {hs_sync_q[0], hsync};
      vs_sync_q <= {vs_sync_q[0], vsync};
    end
  end

  assign hs_in = hs_sync_q[1];
  assign vs_in = vs_sync_q[1];
`else
  assign hs_in = hsync;
  assign vs_in = vsync;
`endif

  logic       hs_prev_q, vs_prev_q;
  logic       vs_armed_q, vs_armed_d;
  logic       frame_bad_q, frame_bad_d;
  logic       line_err_q, line_err_d;
  logic       frame_err_q, frame_err_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [9:0] h_total_q, h_total_d;
  logic [9:0] v_total_q, v_total_d;
  logic [1:0] state_q, state_d;
  logic [3:0] good_cnt_q, good_cnt_d;

  logic        hs_fall, vs_fall, boundary, line_bad, frame_len_bad;
  logic [10:0] h_len, v_len;

  function automatic logic [9:0] sat10(input logic [10:0] v);
    return v[10] ? CNT_MAX : v[9:0];
  endfunction

  assign hs_fall       = hs_prev_q & ~hs_in;
  assign vs_fall       = vs_prev_q & ~vs_in;
  assign boundary      = hs_fall & (vs_armed_q | vs_fall);
  assign h_len         = {1'b0, h_cnt_q} + 11'd1;
  assign v_len         = {1'b0, v_cnt_q} + 11'd1;
  assign line_bad      = (h_len != H_TOTAL_L);
  assign frame_len_bad = (v_len != V_TOTAL_L);

  always_comb begin
    h_cnt_d     = hs_fall ? 10'd0 : sat10(h_len);
    h_total_d   = hs_fall ? sat10(h_len) : h_total_q;
    v_cnt_d     = v_cnt_q;
    v_total_d   = v_total_q;
    vs_armed_d  = hs_fall ? 1'b0 : (vs_armed_q | vs_fall);
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    frame_bad_d = frame_bad_q;
    line_err_d  = 1'b0;
    frame_err_d = 1'b0;

    if (boundary) begin
      v_cnt_d   = 10'd0;
      v_total_d = sat10(v_len);
    end else if (hs_fall) begin
      v_cnt_d = sat10(v_len);
    end

    case (state_q)
      S_SEARCH: begin
        if (boundary) begin
          state_d     = S_TRACK;
          good_cnt_d  = 4'd0;
          frame_bad_d = 1'b0;
        end
      end
      default: begin
        if (hs_fall) begin
          line_err_d  = line_bad;
          frame_err_d = boundary & frame_len_bad;
          frame_bad_d = boundary ? 1'b0 : (frame_bad_q | line_bad);
          if (state_q == S_LOCKED) begin
            if (line_bad | (boundary & frame_len_bad)) begin
              state_d    = S_TRACK;
              good_cnt_d = 4'd0;
            end
          end else if (boundary) begin
            // a bad last line spoils the frame it closes
            if (line_bad | frame_len_bad | frame_bad_q) begin
              good_cnt_d = 4'd0;
            end else if (good_cnt_q + 4'd1 == LOCK_L) begin
              good_cnt_d = LOCK_L;
              state_d    = S_LOCKED;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end
        end
      end
    endcase

    // hsync lost: drop lock in the same cycle h_cnt saturates
    if (h_cnt_d == CNT_MAX) begin
      state_d     = S_SEARCH;
      good_cnt_d  = 4'd0;
      frame_bad_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      vs_armed_q  <= 1'b0;
      frame_bad_q <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      h_cnt_q     <= 10'd0;
      v_cnt_q     <= 10'd0;
      h_total_q   <= 10'd0;
      v_total_q   <= 10'd0;
      state_q     <= S_SEARCH;
      good_cnt_q  <= 4'd0;
    end else begin
      hs_prev_q   <= hs_in;
      vs_prev_q   <= vs_in;
      vs_armed_q  <= vs_armed_d;
      frame_bad_q <= frame_bad_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      h_total_q   <= h_total_d;
      v_total_q   <= v_total_d;
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
    end
  end

  assign x_pos     = h_cnt_q - HBP_L;
  assign y_pos     = v_cnt_q - VBP_L;
  assign locked    = (state_q == S_LOCKED);
  assign valid     = locked & (h_cnt_q > HBP_L) & (h_cnt_q < HFP_L)
                   & (v_cnt_q > VBP_L) & (v_cnt_q < VFP_L);
  assign h_total   = h_total_q;
  assign v_total   = v_total_q;
  assign line_err  = line_err_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder (default build): scaled-down raster, directed scenarios plus random frames
// checked every cycle against a timestamp-based reference model.
module tb_vga_sync_decoder;
  localparam int H_T  = 64;
  localparam int V_T  = 12;
  localparam int HB   = 16;
  localparam int HF   = 56;
  localparam int VB   = 3;
  localparam int VF   = 10;
  localparam int LK   = 2;
  localparam int HS_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hsync = 1'b1;
  logic vsync = 1'b1;
  logic [9:0] x_pos, y_pos, h_total, v_total;
  logic valid, locked, line_err, frame_err;

  int total = 0;
  int bad = 0;

  vga_sync_decoder #(
    .H_TOTAL(H_T), .V_TOTAL(V_T), .HBP(HB), .HFP(HF),
    .VBP(VB), .VFP(VF), .LOCK_FRAMES(LK)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .x_pos(x_pos), .y_pos(y_pos), .valid(valid), .locked(locked),
    .h_total(h_total), .v_total(v_total),
    .line_err(line_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: horizontal position is the age of the last hsync fall,
  // vertical position the number of lines since the last frame boundary.
  int m_cyc = 0, m_last = 0, m_lines = 0, m_htot = 0, m_vtot = 0;
  int m_state = 0, m_good = 0;
  bit m_live = 0, m_hp = 0, m_vp = 0, m_armed = 0, m_fbad = 0, m_le = 0, m_fe = 0;

  function automatic int sat(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic model_step(input bit r, input bit hs, input bit vs);
    bit hf, vf, bnd;
    int line_len, frame_len;
    if (r) begin
      m_live = 1; m_last = m_cyc; m_lines = 0; m_htot = 0; m_vtot = 0;
      m_state = 0; m_good = 0; m_hp = 0; m_vp = 0; m_armed = 0;
      m_fbad = 0; m_le = 0; m_fe = 0;
      return;
    end
    hf = m_hp && !hs;
    vf = m_vp && !vs;
    bnd = hf && (m_armed || vf);
    line_len = sat(m_cyc - 1 - m_last) + 1;
    m_le = 0;
    m_fe = 0;
    if (hf) begin
      m_htot = sat(line_len);
      m_last = m_cyc;
      frame_len = m_lines + 1;
      if (bnd) begin
        m_vtot = sat(frame_len);
        m_lines = 0;
      end else begin
        m_lines = sat(frame_len);
      end
      if (m_state == 0) begin
        if (bnd) begin m_state = 1; m_good = 0; m_fbad = 0; end
      end else begin
        m_le = (line_len != H_T);
        m_fe = bnd && (frame_len != V_T);
        if (m_state == 2) begin
          if (m_le || m_fe) begin m_state = 1; m_good = 0; end
        end else if (bnd) begin
          if (m_le || m_fe || m_fbad) m_good = 0;
          else begin
            m_good++;
            if (m_good == LK) m_state = 2;
          end
        end
        m_fbad = bnd ? 1'b0 : (m_fbad || m_le);
      end
    end
    m_armed = hf ? 1'b0 : (m_armed || vf);
    m_hp = hs;
    m_vp = vs;
    if (m_cyc - m_last >= 1023) begin m_state = 0; m_good = 0; m_fbad = 0; end
  endtask

  always @(posedge clk) begin : cmp
    int h;
    bit lk;
    m_cyc++;
    model_step(rst, hsync, vsync);
    #1;
    if (m_live) begin
      h  = sat(m_cyc - m_last);
      lk = (m_state == 2);
      check("x_pos", x_pos, (h - HB) & 1023);
      check("y_pos", y_pos, (m_lines - VB) & 1023);
      check("locked", locked, lk);
      check("valid", valid, lk && h > HB && h < HF && m_lines > VB && m_lines < VF);
      check("h_total", h_total, m_htot);
      check("v_total", v_total, m_vtot);
      check("line_err", line_err, m_le);
      check("frame_err", frame_err, m_fe);
    end
  end

  task automatic drive(input bit hs, input bit vs, input bit r);
    @(negedge clk);
    hsync = hs;
    vsync = vs;
    rst = r;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_x_pos"}, x_pos, 1008);
    check({tag, "_y_pos"}, y_pos, 1021);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_h_total"}, h_total, 0);
    check({tag, "_v_total"}, v_total, 0);
    check({tag, "_line_err"}, line_err, 0);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  // mode: 0 none, 1 position checks, 2 short-line error, 3 frame error at start,
  //       4 locked at start, 5 unlocked at start
  task automatic send_frame(input int nlines, input int short_y, input int short_len,
                            input int mode, input int rst_y, input int vs_off);
    for (int y = 0; y < nlines; y++) begin
      int len;
      len = (y == short_y) ? short_len : H_T;
      for (int x = 0; x < len; x++) begin
        bit vl;
        vl = (y == 0 && x >= vs_off) || (y == 1) || (y == 2 && x < vs_off);
        drive(x >= HS_W, !vl, (y == rst_y) && (x == 20));
        if (y == rst_y && x == 20) begin
          post();
          chk_reset("midrst");
        end else if (mode == 1 && y == VB + 1 && x == HB + 1) begin
          post();
          check("act_valid", valid, 1);
          check("act_x_pos", x_pos, 1);
          check("act_y_pos", y_pos, 1);
          check("lock_h_total", h_total, 64);
          check("lock_v_total", v_total, 12);
        end else if (mode == 1 && y == VB + 1 && x == HF - 1) begin
          post();
          check("last_valid", valid, 1);
        end else if (mode == 1 && y == VB + 1 && x == HF) begin
          post();
          check("hfp_valid", valid, 0);
        end else if (mode == 2 && y == short_y + 1 && x == 0) begin
          post();
          check("short_line_err", line_err, 1);
          check("short_locked", locked, 0);
          check("short_h_total", h_total, 63);
        end else if (mode == 2 && y == short_y + 1 && x == 1) begin
          post();
          check("short_err_once", line_err, 0);
        end else if (mode == 3 && y == 0 && x == 0) begin
          post();
          check("frame_err", frame_err, 1);
          check("short_v_total", v_total, 11);
          check("frame_locked", locked, 0);
        end else if ((mode == 4 || mode == 5) && y == 0 && x == 0) begin
          post();
          check("start_locked", locked, mode == 4);
        end
      end
    end
  endtask

  initial begin
    bit prev_l, found;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    repeat (3) drive(1, 1, 0);

    send_frame(V_T, -1, H_T, 0, -1, 0);
    send_frame(V_T, -1, H_T, 5, -1, 0);
    send_frame(V_T, -1, H_T, 1, -1, 0);
    send_frame(V_T, 5, 63, 2, -1, 0);
    send_frame(V_T, -1, H_T, 5, -1, 0);
    send_frame(V_T, -1, H_T, 5, -1, 0);
    send_frame(V_T - 1, -1, H_T, 4, -1, 0);
    send_frame(V_T, -1, H_T, 3, -1, 0);
    send_frame(V_T, -1, H_T, 5, -1, 0);
    send_frame(V_T, -1, H_T, 4, -1, 0);

    prev_l = locked;
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      drive(1, 1, 0);
      post();
      if (x_pos == 10'd1007) begin
        found = 1;
        check("lost_locked", locked, 0);
        check("lost_prev_locked", prev_l, 1);
      end
      prev_l = locked;
    end
    check("lost_seen", found, 1);

    send_frame(V_T, -1, H_T, 0, 5, 0);

    for (int f = 0; f < 40; f++) begin
      int nl, sy, sl, ry, vo;
      nl = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 14) : V_T;
      sy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1;
      sl = $urandom_range(58, 70);
      ry = ($urandom_range(0, 19) == 0) ? $urandom_range(2, nl - 1) : -1;
      vo = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 50) : 0;
      send_frame(nl, sy, sl, 0, ry, vo);
    end
    repeat (4) drive(1, 1, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the 640x480@60 VGA timing generator: a single-clock-domain block that recovers raster position from incoming hsync/vsync.
- Takes active-low hsync/vsync pulses clocked on the pixel clock, rebuilds horizontal/vertical counters and measures line and frame lengths.
- Locks onto the expected mode and outputs recovered x_pos/y_pos/valid.
- Used by capture, overlay and loopback-check logic downstream of a VGA source.

Parameters:
- H_TOTAL, 800, expected clocks per line
- V_TOTAL, 521, expected lines per frame
- HBP, 144, horizontal active-start reference; valid when h_cnt > HBP
- HFP, 784, horizontal active-end; valid when h_cnt < HFP
- VBP, 31, vertical active-start reference
- VFP, 511, vertical active-end
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)

Ports:
- clk  in  1  pixel clock; everything on rising edge
- rst  in  1  synchronous, active-high reset
- hsync  in  1  active-low horizontal sync
- vsync  in  1  active-low vertical sync
- x_pos  out  10  h_cnt - HBP, mod 1024
- y_pos  out  10  v_cnt - VBP, mod 1024
- valid  out  1  active-region pixel; forced 0 unless locked
- locked  out  1  state == LOCKED
- h_total  out  10  last measured line length in clocks
- v_total  out  10  last measured frame length in lines
- line_err  out  1  one-cycle pulse: line length != H_TOTAL while TRACK/LOCKED
- frame_err  out  1  one-cycle pulse: frame length != V_TOTAL while TRACK/LOCKED

Behaviour:
- Synchronous, active-high reset. Reset values:
  - hs_prev = vs_prev = 0, so no spurious edge out of reset.
  - h_cnt = v_cnt = 0, h_total = v_total = 0.
  - vs_armed = 0, state = SEARCH, good_cnt = 0.
  - locked, valid, line_err and frame_err all 0.
  - x_pos = 880 and y_pos = 993 follow from counters at 0.
- Edge detection:
  - hs_fall = hs_prev & ~hsync; vs_fall = vs_prev & ~vsync.
  - hs_prev and vs_prev are registered every cycle.
- h_cnt:
  - On hs_fall: h_cnt <= 0 and h_total <= min(h_cnt + 1, 1023).
  - Otherwise h_cnt increments, saturating at 1023.
  - Net effect: h_cnt equals the source's horizontal count delayed by exactly 1 clock.
- vs_armed: set on vs_fall; cleared by the hs_fall that consumes it. A same-cycle vs_fall counts as armed.
- Frame boundary = hs_fall with vs_armed or vs_fall. At a frame boundary: v_cnt <= 0 and v_total <= min(v_cnt + 1, 1023).
- On any other hs_fall: v_cnt increments, saturating at 1023.
- State machine:
  - SEARCH -> TRACK on the first frame boundary. good_cnt <= 0 and frame_bad <= 0; no length checks on this edge.
  - TRACK/LOCKED, each hs_fall: if h_cnt + 1 != H_TOTAL, pulse line_err the next cycle and set frame_bad.
  - TRACK, frame boundary: if v_cnt + 1 != V_TOTAL, pulse frame_err.
    - Error or frame_bad: good_cnt <= 0.
    - Otherwise good_cnt + 1; on reaching LOCK_FRAMES -> LOCKED.
    - frame_bad is cleared at every boundary.
  - LOCKED: any line_err or frame_err -> TRACK, good_cnt <= 0.
  - Any state: h_cnt reaches 1023 (hsync lost) -> SEARCH, the same cycle locked falls.
- valid = locked & (h_cnt > HBP) & (h_cnt < HFP) & (v_cnt > VBP) & (v_cnt < VFP), combinational from registers.
- Latency: outputs trail the source position by 1 clock.
- Simultaneous line and frame errors: both pulses fire in the same cycle.
- Reset mid-frame returns to SEARCH; relock needs a boundary plus LOCK_FRAMES good frames.

Optional Feature:
- Macro: VGA_DEC_SYNC_EN.
- Defined: hsync and vsync each pass through a 2-flop synchronizer before edge detection, for asynchronous sources. Total latency becomes 3 clocks; counters and checks are unchanged.
- Undefined: inputs are used directly with 1-clock latency; the inputs must already be synchronous to clk.

Test Plan:
- Feed a standard 800x521 stream (hsync low for counts 0..95, vsync low for lines 0..1).
  - SEARCH -> TRACK at the first frame boundary.
  - locked rises on the 2nd subsequent clean boundary; h_total = 800, v_total = 521.
- Locked stream, source at x = 145, y = 32 -> next clock: valid = 1, x_pos = 1, y_pos = 1. At source x = 784 -> next clock valid = 0.
- Locked, shorten one line to 799 clocks -> line_err pulses once and locked falls. Relock after 2 clean frames following the next boundary.
- Frame of 520 lines while TRACK/LOCKED -> frame_err pulses once, v_total = 520, locked = 0.
- Hold hsync high after lock -> h_cnt saturates at 1023 and locked drops that cycle. Assert rst mid-frame -> all outputs at their reset values the next cycle.
- VGA_DEC_SYNC_EN defined, repeat scenario 2 -> valid and x_pos = 1 appear 3 clocks after source x = 145.
